// File: rtl/wb_arbiter_pkg.sv
// Shared types for the execution-stage writeback path: register tags,
// exception codes, unit indices and the writeback bundle.
package wb_arbiter_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_W = 6;
    localparam int EXP_CODE_W = 4;

    localparam int WB_UNIT_ALU = 0;
    localparam int WB_UNIT_MUL = 1;
    localparam int WB_UNIT_FPU = 2;
    localparam int WB_UNIT_MEM = 3;

    typedef enum logic [1:0] {
        TYPE_ARCH = 2'd0,
        TYPE_ROB  = 2'd1
    } reg_type_t;

    typedef struct packed {
        reg_type_t               rtype;
        logic [REG_ADDR_W-1:0]   addr;
    } reg_file_t;

    typedef logic [EXP_CODE_W-1:0] exp_code_t;

    // Writeback bundle at the default data width; flags are active-low.
    typedef struct packed {
        reg_file_t               rd;
        logic [DATA_WIDTH-1:0]   data;
        logic                    exp_;
        exp_code_t               exp_code;
        logic                    pred_miss_;
        logic                    jump_miss_;
    } wb_bus_t;

endpackage

// File: rtl/wb_arbiter_rr.sv
// Round-robin priority select: scans from ptr upward (mod UNITS) and grants
// the first active-low request. Reusable for issue selection.
module wb_arbiter_rr #(
    parameter  int UNITS = 4,
    localparam int UNIT  = $clog2(UNITS)
) (
    input  logic [UNITS-1:0] req_,
    input  logic [UNIT-1:0]  ptr,
    input  logic             en,
    output logic [UNITS-1:0] gnt,
    output logic [UNIT-1:0]  idx,
    output logic             vld
);

    logic [UNIT-1:0] scan_idx [UNITS];

    for (genvar gi = 0; gi < UNITS; gi++) begin : g_scan
        assign scan_idx[gi] = UNIT'((int'(ptr) + gi) % UNITS);
    end

    // Walk from farthest to nearest so the closest requester after ptr wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        for (int off = UNITS - 1; off >= 0; off--) begin
            if (en && !req_[scan_idx[off]]) begin
                vld = 1'b1;
                idx = scan_idx[off];
            end
        end
        if (vld) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin grant with same-cycle ack and early wakeup,
// then registers the granted unit's writeback onto the common data bus.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter  int DATA  = DATA_WIDTH,
    parameter  int UNITS = 4,
    localparam int UNIT  = $clog2(UNITS)
) (
    input  logic                        clk,
    input  logic                        reset_,
    input  logic                        flush_,
    input  logic [UNITS-1:0]            req_,
    input  reg_file_t [UNITS-1:0]       pre_rd,
    output logic [UNITS-1:0]            ack_,
    input  logic [UNITS-1:0]            wb_e_,
    input  reg_file_t [UNITS-1:0]       wb_rd,
    input  logic [UNITS-1:0][DATA-1:0]  wb_data,
    input  logic [UNITS-1:0]            wb_exp_,
    input  exp_code_t [UNITS-1:0]       wb_exp_code,
    input  logic [UNITS-1:0]            wb_pred_miss_,
    input  logic [UNITS-1:0]            wb_jump_miss_,
    output logic                        cdb_pre_e_,
    output reg_file_t                   cdb_pre_rd,
    output logic                        cdb_e_,
    output reg_file_t                   cdb_rd,
    output logic [DATA-1:0]             cdb_data,
    output logic                        cdb_exp_,
    output exp_code_t                   cdb_exp_code,
    output logic                        cdb_pred_miss_,
    output logic                        cdb_jump_miss_
);

    logic [UNIT-1:0]  ptr_reg;
    logic [UNIT-1:0]  ptr_next;
    logic [UNIT-1:0]  g_reg;
    logic             gv_reg;
    logic             arb_en;
    logic [UNITS-1:0] gnt;
    logic [UNIT-1:0]  gnt_idx;
    logic             gnt_vld;
    logic             capture;

    // No grant may leave the arbiter while in reset or during a flush.
    assign arb_en = reset_ & flush_;

    wb_arbiter_rr #(
        .UNITS (UNITS)
    ) u_rr (
        .req_ (req_),
        .ptr  (ptr_reg),
        .en   (arb_en),
        .gnt  (gnt),
        .idx  (gnt_idx),
        .vld  (gnt_vld)
    );

    assign ack_       = ~gnt;
    assign cdb_pre_e_ = ~gnt_vld;
    assign cdb_pre_rd = gnt_vld ? pre_rd[gnt_idx] : '0;
    assign ptr_next   = (gnt_idx == UNIT'(UNITS - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ptr_reg <= '0;
            g_reg   <= '0;
            gv_reg  <= 1'b0;
        end else if (gnt_vld) begin
            ptr_reg <= ptr_next;
            g_reg   <= gnt_idx;
            gv_reg  <= 1'b1;
        end else begin
            gv_reg  <= 1'b0;
        end
    end

    assign capture = flush_ & gv_reg & ~wb_e_[g_reg];

    // An idle bus stage matches its reset image: flags deasserted, payload zero.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cdb_e_         <= 1'b1;
            cdb_rd         <= '0;
            cdb_data       <= '0;
            cdb_exp_       <= 1'b1;
            cdb_exp_code   <= '0;
            cdb_pred_miss_ <= 1'b1;
            cdb_jump_miss_ <= 1'b1;
        end else if (capture) begin
            cdb_e_         <= 1'b0;
            cdb_rd         <= wb_rd[g_reg];
            cdb_data       <= wb_data[g_reg];
            cdb_exp_       <= wb_exp_[g_reg];
            cdb_exp_code   <= wb_exp_code[g_reg];
            cdb_pred_miss_ <= wb_pred_miss_[g_reg];
            cdb_jump_miss_ <= wb_jump_miss_[g_reg];
        end else begin
            cdb_e_         <= 1'b1;
            cdb_rd         <= '0;
            cdb_data       <= '0;
            cdb_exp_       <= 1'b1;
            cdb_exp_code   <= '0;
            cdb_pred_miss_ <= 1'b1;
            cdb_jump_miss_ <= 1'b1;
        end
    end

    // A unit writing back without holding the previous cycle's grant is ignored.
    for (genvar gi = 0; gi < UNITS; gi++) begin : g_wb_check
        always @(posedge clk) begin
            if (reset_ && !wb_e_[gi]) begin
                assert (gv_reg && g_reg == UNIT'(gi))
                    else $error("wb_arbiter: unit %0d drove wb_e_ without a grant", gi);
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized
// traffic checked against a behavioural round-robin/writeback model.
`timescale 1ns/1ps
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        logic       e_;
        reg_file_t  rd;
        logic [31:0] data;
        logic       exp_;
        exp_code_t  code;
        logic       pm_;
        logic       jm_;
    } bus_t;

    localparam bus_t BUS_IDLE = '{e_: 1'b1, rd: '0, data: '0, exp_: 1'b1,
                                  code: '0, pm_: 1'b1, jm_: 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset_, flush_;
    logic [N-1:0]        req_, ack_;
    reg_file_t [N-1:0]   pre_rd;
    logic [N-1:0]        wb_e_, wb_exp_, wb_pred_miss_, wb_jump_miss_;
    reg_file_t [N-1:0]   wb_rd;
    logic [N-1:0][31:0]  wb_data;
    exp_code_t [N-1:0]   wb_exp_code;
    logic                cdb_pre_e_, cdb_e_, cdb_exp_, cdb_pred_miss_, cdb_jump_miss_;
    reg_file_t           cdb_pre_rd, cdb_rd;
    logic [31:0]         cdb_data;
    exp_code_t           cdb_exp_code;
    bus_t                obs_bus;

    assign obs_bus = {cdb_e_, cdb_rd, cdb_data, cdb_exp_, cdb_exp_code,
                      cdb_pred_miss_, cdb_jump_miss_};

    wb_arbiter #(.DATA(32), .UNITS(N)) dut (
        .clk            (clk),
        .reset_         (reset_),
        .flush_         (flush_),
        .req_           (req_),
        .pre_rd         (pre_rd),
        .ack_           (ack_),
        .wb_e_          (wb_e_),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .wb_exp_        (wb_exp_),
        .wb_exp_code    (wb_exp_code),
        .wb_pred_miss_  (wb_pred_miss_),
        .wb_jump_miss_  (wb_jump_miss_),
        .cdb_pre_e_     (cdb_pre_e_),
        .cdb_pre_rd     (cdb_pre_rd),
        .cdb_e_         (cdb_e_),
        .cdb_rd         (cdb_rd),
        .cdb_data       (cdb_data),
        .cdb_exp_       (cdb_exp_),
        .cdb_exp_code   (cdb_exp_code),
        .cdb_pred_miss_ (cdb_pred_miss_),
        .cdb_jump_miss_ (cdb_jump_miss_)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int         m_ptr;
    int         m_last_g;
    int         m_grant;
    logic [N-1:0] exp_ack;
    logic       exp_pre_e_;
    reg_file_t  exp_pre_rd;
    bus_t       exp_bus;
    bus_t       nxt_bus;
    bit         fix_en;
    bus_t       fix_bus;

    function automatic int rr_pick(logic [N-1:0] rq, int p, logic fl_n);
        if (!fl_n) return -1;
        for (int k = 0; k < N; k++) begin
            if (!rq[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic reg_file_t rand_rd();
        reg_file_t r;
        r.rtype = ($urandom_range(0, 1) != 0) ? TYPE_ROB : TYPE_ARCH;
        r.addr  = 6'($urandom);
        return r;
    endfunction

    task automatic wb_idle();
        wb_e_ = '1; wb_rd = '0; wb_data = '0; wb_exp_ = '1;
        wb_exp_code = '0; wb_pred_miss_ = '1; wb_jump_miss_ = '1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_last_g = -1; m_grant = -1;
        nxt_bus = BUS_IDLE; exp_bus = BUS_IDLE; fix_en = 0;
    endtask

    task automatic do_reset();
        reset_ = 1'b0; flush_ = 1'b1; req_ = '1; pre_rd = '0;
        wb_idle();
        repeat (2) @(posedge clk);
        #1 reset_ = 1'b1;
        model_reset();
    endtask

    // Apply one cycle of stimulus (called at posedge+1), compute expectations,
    // then wait for the sampling edge.
    task automatic advance(input logic [N-1:0] rq, input reg_file_t [N-1:0] prd,
                           input logic fl_n);
        bus_t w;
        int g;
        exp_bus = nxt_bus;
        wb_idle();
        nxt_bus = BUS_IDLE;
        if (m_last_g >= 0) begin
            if (fix_en) begin
                w = fix_bus;
            end else begin
                w.rd   = rand_rd();
                w.data = $urandom;
                w.exp_ = ($urandom_range(0, 3) != 0);
                w.code = 4'($urandom);
                w.pm_  = 1'($urandom_range(0, 1));
                w.jm_  = 1'($urandom_range(0, 1));
            end
            w.e_ = 1'b0;
            fix_en = 0;
            wb_e_[m_last_g]         = 1'b0;
            wb_rd[m_last_g]         = w.rd;
            wb_data[m_last_g]       = w.data;
            wb_exp_[m_last_g]       = w.exp_;
            wb_exp_code[m_last_g]   = w.code;
            wb_pred_miss_[m_last_g] = w.pm_;
            wb_jump_miss_[m_last_g] = w.jm_;
            if (fl_n) nxt_bus = w;
        end
        req_ = rq; pre_rd = prd; flush_ = fl_n;
        g = rr_pick(rq, m_ptr, fl_n);
        exp_ack = '1; exp_pre_e_ = 1'b1; exp_pre_rd = '0;
        if (g >= 0) begin
            exp_ack[g] = 1'b0; exp_pre_e_ = 1'b0; exp_pre_rd = prd[g];
            m_ptr = (g + 1) % N;
        end
        m_last_g = g;
        m_grant  = g;
        @(negedge clk);
        $display("txn t=%0t req_=%b flush_=%b ack_=%b cdb_e_=%b cdb_data=%h",
                 $time, rq, fl_n, ack_, cdb_e_, cdb_data);
    endtask

    task automatic test_reset();
        reset_ = 1'b0; flush_ = 1'b1; req_ = '0;
        for (int u = 0; u < N; u++) pre_rd[u] = '{rtype: TYPE_ROB, addr: 6'd5};
        wb_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (ack_ !== 4'hF) begin bad++; $display("FAIL reset_ack: got %b want 1111", ack_); end
        total++; if (cdb_pre_e_ !== 1'b1) begin bad++; $display("FAIL reset_pre_e: got %b want 1", cdb_pre_e_); end
        total++; if (obs_bus !== BUS_IDLE) begin bad++; $display("FAIL reset_bus: got %h want %h", obs_bus, BUS_IDLE); end
        total++; if (cdb_pre_rd !== '0) begin bad++; $display("FAIL reset_pre_rd: got %h want 0", cdb_pre_rd); end
        @(posedge clk);
        #1 reset_ = 1'b1; req_ = '1;
        model_reset();
    endtask

    task automatic test_single();
        reg_file_t [N-1:0] prd;
        prd = '0;
        prd[0] = '{rtype: TYPE_ROB, addr: 6'd2};
        advance(4'b1110, prd, 1'b1);
        total++; if (ack_ !== 4'b1110) begin bad++; $display("FAIL single_ack: got %b want 1110", ack_); end
        total++; if (cdb_pre_e_ !== 1'b0) begin bad++; $display("FAIL single_pre_e: got %b want 0", cdb_pre_e_); end
        total++; if (cdb_pre_rd !== prd[0]) begin bad++; $display("FAIL single_pre_rd: got %h want %h", cdb_pre_rd, prd[0]); end
        tick();
        fix_en = 1;
        fix_bus = '{e_: 1'b0, rd: prd[0], data: 32'd9, exp_: 1'b1, code: '0, pm_: 1'b1, jm_: 1'b1};
        advance('1, prd, 1'b1);
        total++; if (cdb_e_ !== 1'b1) begin bad++; $display("FAIL single_early_bus: got %b want 1", cdb_e_); end
        tick();
        advance('1, prd, 1'b1);
        total++; if (cdb_e_ !== 1'b0 || cdb_data !== 32'd9) begin
            bad++; $display("FAIL single_bus: got e_=%b data=%h want e_=0 data=9", cdb_e_, cdb_data); end
        total++; if (cdb_rd !== prd[0]) begin bad++; $display("FAIL single_rd: got %h want %h", cdb_rd, prd[0]); end
        tick();
    endtask

    task automatic test_contention();
        reg_file_t [N-1:0] prd;
        logic [N-1:0] want;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            for (int u = 0; u < N; u++) prd[u] = rand_rd();
            advance((c < 5) ? 4'b0000 : 4'b1111, prd, 1'b1);
            want = (c < 5) ? ~(4'b0001 << (c % N)) : 4'b1111;
            total++; if (ack_ !== want) begin bad++; $display("FAIL contend_ack c=%0d: got %b want %b", c, ack_, want); end
            total++; if (obs_bus !== exp_bus) begin bad++; $display("FAIL contend_bus c=%0d: got %h want %h", c, obs_bus, exp_bus); end
            if (c >= 2) begin
                total++; if (cdb_e_ !== 1'b0) begin bad++; $display("FAIL contend_cdb_e c=%0d: got %b want 0", c, cdb_e_); end
            end
            tick();
        end
    endtask

    task automatic test_fairness();
        reg_file_t [N-1:0] prd;
        logic [N-1:0] rq;
        bit pend3 = 0, got3 = 0;
        int wait3 = 0, ones = 0;
        prd = '0;
        for (int c = 0; c < 12; c++) begin
            rq = 4'b1111;
            rq[1] = 1'b0;
            prd[1] = rand_rd();
            if (c == 5) begin pend3 = 1; prd[3] = rand_rd(); end
            if (pend3) rq[3] = 1'b0;
            advance(rq, prd, 1'b1);
            total++; if (ack_ !== exp_ack) begin bad++; $display("FAIL fair_ack c=%0d: got %b want %b", c, ack_, exp_ack); end
            total++; if (obs_bus !== exp_bus) begin bad++; $display("FAIL fair_bus c=%0d: got %h want %h", c, obs_bus, exp_bus); end
            if (pend3) begin
                if (!ack_[3]) got3 = 1; else wait3++;
                if (!ack_[1]) ones++;
            end
            if (m_grant == 3) pend3 = 0;
            tick();
        end
        total++; if (!got3 || wait3 > N - 1) begin bad++; $display("FAIL fair_unit3: got granted=%0d waited=%0d want granted=1 waited<=3", got3, wait3); end
        total++; if (ones > 1) begin bad++; $display("FAIL fair_unit1: got %0d grants while 3 waited want <=1", ones); end
    endtask

    task automatic test_flush();
        reg_file_t [N-1:0] prd;
        for (int u = 0; u < N; u++) prd[u] = rand_rd();
        advance(4'b1011, prd, 1'b1);
        total++; if (ack_ !== 4'b1011) begin bad++; $display("FAIL flush_grant2: got %b want 1011", ack_); end
        tick();
        advance(4'b1110, prd, 1'b0);
        total++; if (ack_ !== 4'b1111 || cdb_pre_e_ !== 1'b1) begin
            bad++; $display("FAIL flush_no_ack: got ack_=%b pre_e_=%b want 1111/1", ack_, cdb_pre_e_); end
        tick();
        advance(4'b1110, prd, 1'b1);
        total++; if (cdb_e_ !== 1'b1) begin bad++; $display("FAIL flush_bus: got cdb_e_=%b want 1", cdb_e_); end
        total++; if (ack_ !== exp_ack) begin bad++; $display("FAIL flush_after_ack: got %b want %b", ack_, exp_ack); end
        tick();
        for (int c = 0; c < 2; c++) begin
            advance('1, prd, 1'b1);
            total++; if (obs_bus !== exp_bus) begin bad++; $display("FAIL flush_drain c=%0d: got %h want %h", c, obs_bus, exp_bus); end
            tick();
        end
    endtask

    task automatic test_exception();
        reg_file_t [N-1:0] prd;
        for (int u = 0; u < N; u++) prd[u] = rand_rd();
        advance(4'b0111, prd, 1'b1);
        total++; if (ack_ !== 4'b0111) begin bad++; $display("FAIL exc_ack: got %b want 0111", ack_); end
        tick();
        fix_en = 1;
        fix_bus = '{e_: 1'b0, rd: prd[3], data: 32'hDEAD_BEEF, exp_: 1'b0, code: 4'hA, pm_: 1'b0, jm_: 1'b1};
        advance('1, prd, 1'b1);
        tick();
        advance('1, prd, 1'b1);
        total++; if (cdb_e_ !== 1'b0 || cdb_exp_ !== 1'b0 || cdb_exp_code !== 4'hA) begin
            bad++; $display("FAIL exc_flags: got e_=%b exp_=%b code=%h want 0/0/a", cdb_e_, cdb_exp_, cdb_exp_code); end
        total++; if (cdb_pred_miss_ !== 1'b0 || cdb_jump_miss_ !== 1'b1 || cdb_data !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL exc_miss: got pm_=%b jm_=%b data=%h want 0/1/deadbeef", cdb_pred_miss_, cdb_jump_miss_, cdb_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        reg_file_t [N-1:0] prd;
        do_reset();
        for (int u = 0; u < N; u++) prd[u] = rand_rd();
        advance(4'b1011, prd, 1'b1);
        tick();
        reset_ = 1'b0;
        wb_idle();
        req_ = 4'b0110;
        #1;
        total++; if (ack_ !== 4'hF || cdb_pre_e_ !== 1'b1) begin
            bad++; $display("FAIL rstmid_ack: got ack_=%b pre_e_=%b want 1111/1", ack_, cdb_pre_e_); end
        total++; if (obs_bus !== BUS_IDLE) begin bad++; $display("FAIL rstmid_bus: got %h want %h", obs_bus, BUS_IDLE); end
        @(posedge clk);
        #1 reset_ = 1'b1;
        model_reset();
        advance(4'b0110, prd, 1'b1);
        total++; if (ack_ !== 4'b1110) begin bad++; $display("FAIL rstmid_regrant: got %b want 1110", ack_); end
        total++; if (obs_bus !== BUS_IDLE) begin bad++; $display("FAIL rstmid_nowb: got %h want %h", obs_bus, BUS_IDLE); end
        tick();
        for (int c = 0; c < 2; c++) begin
            advance('1, prd, 1'b1);
            total++; if (obs_bus !== exp_bus) begin bad++; $display("FAIL rstmid_drain c=%0d: got %h want %h", c, obs_bus, exp_bus); end
            tick();
        end
    endtask

    task automatic test_random();
        reg_file_t [N-1:0] prd;
        logic [N-1:0] rq;
        bit pend [N];
        logic fl_n;
        prd = '0;
        for (int u = 0; u < N; u++) pend[u] = 0;
        for (int c = 0; c < 300; c++) begin
            for (int u = 0; u < N; u++) begin
                if (!pend[u] && $urandom_range(0, 1) != 0) begin
                    pend[u] = 1;
                    prd[u] = rand_rd();
                end
                rq[u] = !pend[u];
            end
            fl_n = ($urandom_range(0, 15) != 0);
            advance(rq, prd, fl_n);
            if (m_grant >= 0) pend[m_grant] = 0;
            total++; if (ack_ !== exp_ack) begin bad++; $display("FAIL rand_ack c=%0d: got %b want %b", c, ack_, exp_ack); end
            total++; if (cdb_pre_e_ !== exp_pre_e_ || cdb_pre_rd !== exp_pre_rd) begin
                bad++; $display("FAIL rand_pre c=%0d: got %b/%h want %b/%h", c, cdb_pre_e_, cdb_pre_rd, exp_pre_e_, exp_pre_rd); end
            total++; if (obs_bus !== exp_bus) begin bad++; $display("FAIL rand_bus c=%0d: got %h want %h", c, obs_bus, exp_bus); end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_flush();
        test_exception();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter for the execution stage. Shares the single common-data / writeback bus between `UNITS` execution units (ALU, multiplier/divider, FPU, load/store). Uses round-robin `wb_req_`/`wb_ack_` handshakes, broadcasts an early wakeup tag, and registers the granted unit's writeback onto the bus toward the ROB and register file.

## Interface
Parameters:
- `DATA`, `` `DataWidth ``: writeback data width.
- `UNITS`, 4: number of requesting execution units. Unit 0 is the ALU. Must be ≥2.
- `UNIT`, `$clog2(UNITS)`: grant index width (derived, not overridden).

Ports:
- `clk`  in  1  clock.
- `reset_`  in  1  reset; single clock domain, asynchronous, active-low.
- `flush_`  in  1  pipeline flush, active-low.
- `req_`  in  UNITS  per-unit writeback request, active-low.
- `pre_rd`  in  UNITS × RegFile_t  per-unit destination tag, valid with `req_`.
- `ack_`  out  UNITS  per-unit grant, active-low, one-hot or none.
- `wb_e_`  in  UNITS  per-unit writeback valid, active-low.
- `wb_rd`  in  UNITS × RegFile_t  per-unit destination.
- `wb_data`  in  UNITS × DATA  per-unit result.
- `wb_exp_`  in  UNITS  per-unit exception flag.
- `wb_exp_code`  in  UNITS × ExpCode_t  per-unit exception code.
- `wb_pred_miss_`, `wb_jump_miss_`  in  UNITS each  per-unit branch/jump mispredict flags.
- `cdb_pre_e_`  out  1  early wakeup valid.
- `cdb_pre_rd`  out  RegFile_t  early wakeup tag.
- `cdb_e_`  out  1  bus writeback valid.
- `cdb_rd`  out  RegFile_t  bus destination.
- `cdb_data`  out  DATA  bus result.
- `cdb_exp_`  out  1  bus exception flag.
- `cdb_exp_code`  out  ExpCode_t  bus exception code.
- `cdb_pred_miss_`, `cdb_jump_miss_`  out  1 each  bus mispredict flags.

## Operation
- State:
  - round-robin pointer `ptr` (UNIT bits);
  - grant register `g_q` (UNIT bits) with valid `gv_q`;
  - registered bus stage (all `cdb_*`).
- Arbitration (combinational, cycle t):
  - scan `i = ptr, ptr+1, … ptr+UNITS-1` modulo UNITS; the first `i` with `req_[i]` low wins `g`;
  - drive `ack_[g]` low, `cdb_pre_e_` low, `cdb_pre_rd = pre_rd[g]`;
  - no request: all `ack_` high, `cdb_pre_e_` high, `cdb_pre_rd = 0`.
- On grant: `ptr <= (g+1) mod UNITS`, with wrap from UNITS-1 to 0; `g_q <= g`; `gv_q <= 1`. Otherwise `gv_q <= 0` and `ptr` holds.
- Requester rules:
  - hold `req_` and `pre_rd` stable until acked;
  - `ack_` lasts exactly one cycle;
  - `req_` low in the cycle after an ack is a new request.
- Capture at t+1: if `gv_q` and `wb_e_[g_q]` is low, register unit `g_q`'s `wb_*` into `cdb_*` and set `cdb_e_` low. Otherwise `cdb_e_` goes high and the other `cdb_*` fields go to 0.
- Protocol violation: `wb_e_[i]` low with `!(gv_q && g_q==i)` is ignored (never reaches bus) and fires a simulation `$error`.
- Flush, when `flush_` is low in a cycle:
  - `ack_` forced high and `cdb_pre_e_` high (combinational);
  - `gv_q <= 0`; bus stage cleared (`cdb_e_` high next edge);
  - in-flight grant data is dropped;
  - `ptr` unchanged.
- Reset: `ptr=0`, `g_q=0`, `gv_q=0`, `cdb_e_`/`cdb_exp_`/`cdb_pred_miss_`/`cdb_jump_miss_` high, `cdb_rd=0`, `cdb_data=0`, `cdb_exp_code=0`. `ack_` all high and `cdb_pre_e_` high while `reset_` is low. Reset mid-handshake discards everything.

## Timing
- Request to ack: 0 cycles (same cycle).
- Ack to unit `wb_e_`: exactly 1 cycle.
- Unit `wb_e_` to `cdb_e_`: 1 cycle (registered). Request to bus: 2 cycles.
- Early wakeup leads `cdb_e_` by 2 cycles.
- Throughput: one grant per cycle, back-to-back grants to different or the same unit allowed; full rate sustained.
- Fairness: a continuously requesting unit is granted within UNITS cycles.
- Simultaneous flush and request: flush wins, no grant issued.
- Simultaneous flush and capture: bus cleared, no writeback.

## Structure
- Shared package `exe.svh`:
  - `` `WbUnitAlu ``/`Mul`/`Fpu`/`Mem` unit index constants;
  - `WbBus_t` struct bundling rd/data/exp/exp_code/pred_miss/jump_miss, used for `wb_*` inputs and the `cdb_*` stage.
- `RegFile_t` and `ExpCode_t` come from `regfile.svh` and `exception.svh`.
- One sub-module: `rr_arbiter`, a parameterized round-robin priority select taking `req_`, `ptr` and an enable, returning the one-hot grant and its encoded index. It is reusable by issue selection.

## Test plan
- Single request: `req_[0]` low with `pre_rd={TYPE_ROB,2}` at t. Same cycle: `ack_=4'b1110`, `cdb_pre_rd` addr 2. Unit drives `wb_data=9` at t+1. At t+2: `cdb_e_` low, `cdb_data=9`.
- Contention: all four `req_` low for 4 cycles from reset (`ptr=0`). Grants in order 0,1,2,3; `cdb_e_` low on 4 consecutive cycles; `ptr` wraps to 0.
- Fairness: unit 1 always requests, unit 3 requests at cycle 5. Unit 3 is granted within ≤4 cycles; unit 1 is never granted twice while 3 waits past its turn.
- Flush: grant to unit 2 at t, `flush_` low at t+1. No `cdb_e_` at t+2. A request during the flush cycle gets no `ack_`.
- Exception passthrough: unit 3 writes back `wb_exp_` low with a nonzero `exp_code` and `wb_pred_miss_` low. All appear unchanged on `cdb_*` 1 cycle later.
- Reset mid-operation: `reset_` low between ack and capture. Outputs take reset values immediately; no bus writeback; the next request is granted from `ptr=0`.
